// File: rtl/result_mem_if_pkg.sv
// Shared definitions for the systolic-array memory interfaces: line geometry
// defaults, geometry helpers and the write-side FSM state type.
package systolic_pkg;

  localparam int unsigned LINE_W   = 4 * 16;
  localparam int unsigned ADDR_LSB = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned line_bits(input int unsigned n_macs, input int unsigned data_w);
    return n_macs * data_w;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned n_macs, input int unsigned data_w);
    return $clog2(n_macs * data_w / 8);
  endfunction

endpackage

// File: rtl/result_mem_if_if.sv
// Result stream (valid/ready/last) and BRAM write port bundle.
// master = result producer side, slave = result_mem_if side.
interface result_mem_if_if #(
  parameter int unsigned N_MACS      = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned BRAM_ADDR_W = $clog2(MEM_DEPTH) + $clog2(N_MACS * DATA_W / 8)
);
  logic                         res_valid;
  logic                         res_ready;
  logic [ACC_W-1:0]             res_data;
  logic                         res_last;
  logic                         bram_en;
  logic [N_MACS*DATA_W/8-1:0]   bram_we;
  logic [BRAM_ADDR_W-1:0]       bram_addr;
  logic [N_MACS*DATA_W-1:0]     bram_din;

  modport master (
    output res_valid, res_data, res_last,
    input  res_ready, bram_en, bram_we, bram_addr, bram_din
  );

  modport slave (
    input  res_valid, res_data, res_last,
    output res_ready, bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/result_mem_if_acc_quant.sv
// Accumulator to stored-width conversion with clamp detect.
// RESULT_SAT_EN selects signed saturation; otherwise low bits are kept.
module acc_quant #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned DATA_W = 16
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] q_o,
  output logic              clamp_o
);
`ifdef RESULT_SAT_EN
  // In range exactly when every bit from the DATA_W sign bit upward agrees.
  logic [ACC_W-DATA_W:0] head;
  assign head = acc_i[ACC_W-1:DATA_W-1];

  always_comb begin
    q_o     = acc_i[DATA_W-1:0];
    clamp_o = 1'b0;
    if (!(&head) && (|head)) begin
      clamp_o = 1'b1;
      q_o     = acc_i[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  logic unused_head;
  assign unused_head = ^acc_i[ACC_W-1:DATA_W];
  assign q_o         = acc_i[DATA_W-1:0];
  assign clamp_o     = 1'b0;
`endif
endmodule

// File: rtl/result_mem_if.sv
// Packs quantized result beats into BRAM lines and writes them with 1-cycle latency.
// Optional signed saturation via RESULT_SAT_EN (see acc_quant).
module result_mem_if
  import systolic_pkg::*;
#(
  parameter int unsigned N_MACS      = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned BRAM_ADDR_W = $clog2(MEM_DEPTH) + $clog2(N_MACS * DATA_W / 8)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(MEM_DEPTH)-1:0] base_addr,
  output logic [$clog2(MEM_DEPTH)-1:0] line_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag,
  result_mem_if_if.slave               bus
);
  localparam int unsigned LA_W   = $clog2(MEM_DEPTH);
  localparam int unsigned LB     = line_bits(N_MACS, DATA_W);
  localparam int unsigned LSB    = addr_lsb(N_MACS, DATA_W);
  localparam int unsigned BPL    = DATA_W / 8;
  localparam int unsigned LANE_W = (N_MACS > 1) ? $clog2(N_MACS) : 1;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [LB-1:0]       pack_q, pack_d, wr_din_q, wr_din_d;
  logic [N_MACS-1:0]   fill_q, fill_d;
  logic [LA_W-1:0]     line_q, line_d, wr_line_q, wr_line_d;
  logic [LB/8-1:0]     wr_we_q, wr_we_d;
  logic                wr_en_q, wr_en_d, sat_q, sat_d;

  logic [DATA_W-1:0]   beat_val;
  logic                beat_clamp;
  logic [LB-1:0]       line_pack;
  logic [N_MACS-1:0]   line_fill;

  acc_quant #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_quant (
    .acc_i   (bus.res_data),
    .q_o     (beat_val),
    .clamp_o (beat_clamp)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    fill_d    = fill_q;
    line_d    = line_q;
    sat_d     = sat_q;
    wr_en_d   = 1'b0;
    wr_we_d   = '0;
    wr_din_d  = wr_din_q;
    wr_line_d = wr_line_q;

    // Current line as it would look with this beat merged in.
    line_pack = pack_q;
    line_fill = fill_q;
    line_pack[lane_q*DATA_W +: DATA_W] = beat_val;
    line_fill[lane_q] = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          line_d  = base_addr;
          lane_d  = '0;
          pack_d  = '0;
          fill_d  = '0;
          sat_d   = 1'b0;
        end
      end
      RUN: begin
        if (bus.res_valid) begin
          sat_d = sat_q | beat_clamp;
          if (lane_q == LANE_W'(N_MACS - 1) || bus.res_last) begin
            wr_en_d   = 1'b1;
            wr_din_d  = line_pack;
            wr_line_d = line_q;
            for (int unsigned i = 0; i < N_MACS; i++) begin
              wr_we_d[i*BPL +: BPL] = {BPL{line_fill[i]}};
            end
            pack_d = '0;
            fill_d = '0;
            lane_d = '0;
            line_d = (line_q == LA_W'(MEM_DEPTH - 1)) ? '0 : line_q + LA_W'(1);
            if (bus.res_last) state_d = DONE;
          end else begin
            pack_d = line_pack;
            fill_d = line_fill;
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      pack_q    <= '0;
      fill_q    <= '0;
      line_q    <= '0;
      sat_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_we_q   <= '0;
      wr_din_q  <= '0;
      wr_line_q <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      fill_q    <= fill_d;
      line_q    <= line_d;
      sat_q     <= sat_d;
      wr_en_q   <= wr_en_d;
      wr_we_q   <= wr_we_d;
      wr_din_q  <= wr_din_d;
      wr_line_q <= wr_line_d;
    end
  end

  assign bus.res_ready = (state_q == RUN);
  assign bus.bram_en   = wr_en_q;
  assign bus.bram_we   = wr_we_q;
  assign bus.bram_addr = BRAM_ADDR_W'({wr_line_q, {LSB{1'b0}}});
  assign bus.bram_din  = wr_din_q;
  assign line_addr     = line_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign sat_flag      = sat_q;
endmodule
